vga_sync_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_test_pattern.sv | 14 +
 rtl/vga_sync_gen.sv | 131 +++++++++++++
 tb/tb_vga_sync_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, coordinate width, rgb24 type and colour-bar table.
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int COORD_W = 10;
  localparam int BAR_W   = 80;

  typedef logic [23:0] rgb24;

  // White, yellow, cyan, green, magenta, red, blue, black from the left edge.
  localparam rgb24 BAR_TABLE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/vga_test_pattern.sv
// vga_test_pattern: combinational column -> colour-bar lookup.
module vga_test_pattern
  import vga_pkg::*;
(
  input  logic [COORD_W-1:0] i_col,
  output rgb24               o_rgb
);

  logic [COORD_W-1:0] w_bar;

  assign w_bar = i_col / COORD_W'(BAR_W);
  assign o_rgb = (w_bar < COORD_W'(8)) ? BAR_TABLE[w_bar[2:0]] : 24'h000000;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing counters, coordinate request stage and pin-aligned output stage.
// Build macro TEST_PATTERN_EN adds the pattern_sel input and an internal colour-bar source.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic               CLOCK_25,
  input  logic               RESET_N,
  input  rgb24               pixel_in,
`ifdef TEST_PATTERN_EN
  input  logic               pattern_sel,
`endif
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_req,
  output logic               frame_start,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS_C  = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;
  logic [COORD_W-1:0] r_pix_x;
  logic [COORD_W-1:0] r_pix_y;
  logic               r_pix_req;
  logic               r_frame_start;
  logic               r_hs1;
  logic               r_vs1;
  logic               r_hs2;
  logic               r_vs2;
  logic               r_blank_n2;
  rgb24               r_rgb;
  rgb24               w_rgb_src;

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Request stage: coordinates go upstream one cycle before the pins need the colour.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_req     <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs1         <= 1'b1;
      r_vs1         <= 1'b1;
    end else begin
      r_pix_x       <= r_h_cnt;
      r_pix_y       <= r_v_cnt;
      r_pix_req     <= (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
      r_hs1         <= !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
      r_vs1         <= !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
    end
  end

`ifdef TEST_PATTERN_EN
  rgb24 w_bar_rgb;

  vga_test_pattern u_test_pattern (
    .i_col (r_pix_x),
    .o_rgb (w_bar_rgb)
  );

  assign w_rgb_src = pattern_sel ? w_bar_rgb : pixel_in;
`else
  assign w_rgb_src = pixel_in;
`endif

  // Output stage: the blank qualifier masks the colour so an undriven pixel_in never reaches the DAC.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hs2      <= 1'b1;
      r_vs2      <= 1'b1;
      r_blank_n2 <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_hs2      <= r_hs1;
      r_vs2      <= r_vs1;
      r_blank_n2 <= r_pix_req;
      r_rgb      <= r_pix_req ? w_rgb_src : 24'h000000;
    end
  end

  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign pix_req     = r_pix_req;
  assign frame_start = r_frame_start;
  assign VGA_CLK     = CLOCK_25;
  assign VGA_HS      = r_hs2;
  assign VGA_VS      = r_vs2;
  assign VGA_BLANK_N = r_blank_n2;
  assign VGA_R       = r_rgb[23:16];
  assign VGA_G       = r_rgb[15:8];
  assign VGA_B       = r_rgb[7:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen using full-width lines and a shortened frame.
module tb_vga_sync_gen;

  // Horizontal timing is the real 640x480 line; the frame is cut to 30 lines so two frames fit the run.
  localparam int HV  = 640;
  localparam int HF  = 16;
  localparam int HSW = 96;
  localparam int HB  = 48;
  localparam int VV  = 20;
  localparam int VF  = 3;
  localparam int VSW = 2;
  localparam int VB  = 5;
  localparam int HT  = HV + HF + HSW + HB;
  localparam int VT  = VV + VF + VSW + VB;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
  } pin_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pixel_in = {24{1'bx}};
  logic [9:0]  pix_x, pix_y;
  logic        pix_req, frame_start;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  bit          pat = 1'b0;
`ifdef TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif

  always #20 clk = ~clk;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .CLOCK_25    (clk),
    .RESET_N     (rst_n),
    .pixel_in    (pixel_in),
`ifdef TEST_PATTERN_EN
    .pattern_sel (pattern_sel),
`endif
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_req     (pix_req),
    .frame_start (frame_start),
    .VGA_CLK     (vga_clk),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VGA_BLANK_N (vga_blank_n),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_ref(input int col);
    case (col / 80)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  int          mh = 0;
  int          mv = 0;
  logic [21:0] exp_s1 = '0;
  pin_exp_t    q[$];

  function automatic logic [26:0] pins_now();
    return {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b};
  endfunction

  task automatic model_reset();
    mh = 0;
    mv = 0;
    exp_s1 = '0;
    q.delete();
  endtask

  task automatic model_step();
    pin_exp_t e;
    logic     req;
    req   = (mh < HV) && (mv < VV);
    e.x   = 10'(mh);
    e.y   = 10'(mv);
    e.hs  = !((mh >= HV + HF) && (mh < HV + HF + HSW));
    e.vs  = !((mv >= VV + VF) && (mv < VV + VF + VSW));
    e.bl  = req;
    e.rgb = !req ? 24'h000000 : (pat ? bar_ref(mh) : {mh[7:0], mv[7:0], 8'hA5});
    exp_s1 = {10'(mh), 10'(mv), req, (mh == 0) && (mv == 0)};
    q.push_back(e);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
  endtask

  task automatic run_cycle();
    pin_exp_t e;
    @(posedge clk);
    model_step();
    #1;
    // Upstream renderer: colour for the requested coordinate, FFFFFF in line blanking, X in frame blanking.
    if (pix_req) pixel_in = {pix_x[7:0], pix_y[7:0], 8'hA5};
    else if (pix_y >= 10'(VV)) pixel_in = {24{1'bx}};
    else pixel_in = 24'hFFFFFF;
    @(negedge clk);
    check_eq("stage1", 64'({pix_x, pix_y, pix_req, frame_start}), 64'(exp_s1));
    if (q.size() == 1) begin
      check_eq("pins_first_edge", 64'(pins_now()), 64'({3'b110, 24'h000000}));
    end else begin
      e = q.pop_front();
      check_eq("pins", 64'(pins_now()), 64'({e.hs, e.vs, e.bl, e.rgb}));
      if (!pat && e.x == 10'(HV - 1) && e.y == 10'(VV - 1))
        check_eq("last_px", 64'({vga_r, vga_g, vga_b}), 64'(24'h7F13A5));  // (639,19)
      if (e.x == 10'(HV) && e.y < 10'(VV))
        check_eq("blank_rgb", 64'({vga_r, vga_g, vga_b}), 64'(24'h000000));
      if (pat && e.y == 10'd0) begin
        case (e.x)
          10'd0, 10'd79: check_eq("bar_col", 64'({vga_r, vga_g, vga_b}), 64'(24'hFFFFFF));
          10'd80:        check_eq("bar_col", 64'({vga_r, vga_g, vga_b}), 64'(24'hFFFF00));
          10'd400:       check_eq("bar_col", 64'({vga_r, vga_g, vga_b}), 64'(24'hFF0000));
          10'd639:       check_eq("bar_col", 64'({vga_r, vga_g, vga_b}), 64'(24'h000000));
          default: ;
        endcase
      end
    end
  endtask

  bit   meas_en = 1'b0;
  int   cyc = 0;
  int   t_hs = -1, t_vs = -1, t_fs = -1, t_bl_r = -1;
  int   nbl = 0;
  bit   bl_fell = 1'b0;
  bit   first_bl = 1'b1;
  logic p_hs = 1'b1, p_vs = 1'b1, p_bl = 1'b0, p_fs = 1'b0;

  // Pin-level timing monitor; a frame is VT*HT = 24000 clocks here (420000 with full 525-line frames).
  always @(negedge clk) begin
    if (meas_en) begin
      cyc++;
      if (!p_bl && vga_blank_n) begin
        if (first_bl) check_eq("first_px", 64'({vga_r, vga_g, vga_b}), 64'(24'h0000A5));
        first_bl = 1'b0;
        t_bl_r = cyc;
        nbl++;
      end
      if (p_bl && !vga_blank_n) begin
        check_eq("blank_width", 64'(cyc - t_bl_r), 64'(HV));
        bl_fell = 1'b1;
        cyc = cyc;
        t_bl_r = cyc;
      end
      if (p_hs && !vga_hs) begin
        if (t_hs >= 0) check_eq("hs_period", 64'(cyc - t_hs), 64'(HT));
        if (bl_fell) check_eq("hs_after_blank", 64'(cyc - t_bl_r), 64'(HF));
        bl_fell = 1'b0;
        t_hs = cyc;
      end
      if (!p_hs && vga_hs && t_hs >= 0) check_eq("hs_low", 64'(cyc - t_hs), 64'(HSW));
      if (p_vs && !vga_vs) begin
        if (t_vs >= 0) begin
          check_eq("vs_period", 64'(cyc - t_vs), 64'(HT * VT));
          check_eq("blank_lines", 64'(nbl), 64'(VV));
        end
        nbl = 0;
        t_vs = cyc;
      end
      if (!p_vs && vga_vs && t_vs >= 0) check_eq("vs_low", 64'(cyc - t_vs), 64'(HT * VSW));
      if (!p_fs && frame_start) begin
        if (t_fs >= 0) check_eq("fs_period", 64'(cyc - t_fs), 64'(HT * VT));
        t_fs = cyc;
      end
      p_hs = vga_hs;
      p_vs = vga_vs;
      p_bl = vga_blank_n;
      p_fs = frame_start;
    end
  end

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("reset_pins", 64'(pins_now()), 64'({3'b110, 24'h000000}));
    check_eq("reset_stage1", 64'({pix_x, pix_y, pix_req, frame_start}), 64'(0));
    rst_n = 1'b1;
    model_reset();
    meas_en = 1'b1;
    repeat (2 * HT * VT + 100) run_cycle();

    for (int i = 0; i < HT * VT && !(mv == 10 && mh == 300); i++) run_cycle();
    meas_en = 1'b0;
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    check_eq("async_rst_pins", 64'(pins_now()), 64'({3'b110, 24'h000000}));
    check_eq("async_rst_stage1", 64'({pix_x, pix_y, pix_req, frame_start}), 64'(0));
`ifdef TEST_PATTERN_EN
    pattern_sel = 1'b1;
    pat = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("held_rst_pins", 64'(pins_now()), 64'({3'b110, 24'h000000}));
    rst_n = 1'b1;
    model_reset();
    repeat (2 * HT + 50) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
